multi_channel_pulse_timer: RTL and testbench
============================================

# multi_channel_pulse_timer

Parametrised successor of the single-channel pulse start timer: NUM_CH independent timers, each controlled by rising edges on start, stand (pause) and reset request lines. Each channel adds a programmable limit with one-shot or periodic reload, a tick-qualified count enable and a done strobe. It sits between the control-register / command decoder and the pulse-generation logic, replacing per-instance single timers.

## Interface
- NUM_CH, 4: number of independent channels (≥1)
- WIDTH, 16: counter width per channel
- INIT_VALUE, 0: value loaded on IDLE and on reload; must fit in WIDTH
- clk  in  1  system clock; all inputs synchronous to it
- rst  in  1  reset, synchronous, active-high
- tick  in  1  count-enable strobe shared by all channels (tie 1 for every-cycle counting)
- timer_start  in  NUM_CH  per-channel start request; rising edge acts
- timer_stand  in  NUM_CH  per-channel pause request; rising edge acts
- timer_reset  in  NUM_CH  per-channel reset request; rising edge acts
- timer_limit  in  NUM_CH*WIDTH  terminal count, channel i at [i*WIDTH +: WIDTH]; sampled each cycle
- timer_periodic  in  NUM_CH  1 = reload on limit, 0 = one-shot
- output_timer  out  NUM_CH*WIDTH  current count, same packing
- timer_done  out  NUM_CH  one-cycle strobe when a channel hits its limit
- timer_busy  out  NUM_CH  high while channel is in COUNTING

## Operation
- Edge detect per control line: registered copy d; edge = in & ~d. d resets to 1, so a line held high through reset does not fire; it must go low then high.
- States per channel: IDLE, COUNTING, STAND, DONE.
- IDLE: count = INIT_VALUE. start edge → COUNTING; else stand edge → STAND.
- COUNTING: reset edge → IDLE; else stand edge → STAND; else if tick: if count == limit → done strobe, then periodic: count ← INIT_VALUE, stay; one-shot: → DONE, count holds; else count ← count + 1.
- STAND: count holds. reset edge → IDLE; else start edge → COUNTING (resume, no reload).
- DONE: count holds at limit. reset edge → IDLE; else start edge → COUNTING with count ← INIT_VALUE.
- Priority within a cycle: reset > stand (in COUNTING) / start (in IDLE, STAND, DONE). start edge in COUNTING ignored; stand edge in STAND/DONE ignored.
- limit == INIT_VALUE: match on first tick after entering COUNTING.
- Channels fully independent; no cross-channel interaction except shared tick.

## Timing
- rst high at an edge: all states IDLE, output_timer = INIT_VALUE per channel, timer_done = 0, timer_busy = 0, edge registers = 1. Applies mid-count; no residual strobe.
- Control line low at edge N-1, high at edge N: state changes at edge N (edge is combinational from registered d); timer_busy high after edge N.
- First increment at edge N+1 if tick high there; count-to-output latency 0 (output_timer is the count register).
- timer_done registered: high for exactly the cycle following the matching edge; consecutive strobes possible in periodic mode with limit == INIT_VALUE and tick = 1.
- Increment is modulo 2^WIDTH unless the macro below is defined.

## Configuration
- PULSE_TIMER_SATURATE_EN defined: in COUNTING the counter holds at all-ones instead of wrapping; a limit below the current count is then never reached (channel remains COUNTING until stand/reset).
- Not defined: all-ones + 1 wraps to 0 and counting continues, so any limit is eventually reached.

## Structure
- Package pulse_timer_pkg: 2-bit state encodings (IDLE 2'b00, COUNTING 2'b10, STAND 2'b01, DONE 2'b11) and the state type.
- Sub-module pulse_timer_channel: one channel (three edge detectors, FSM, counter, done/busy regs), WIDTH and INIT_VALUE parameters; top is a generate loop over NUM_CH with slicing.

## Test plan
- Reset with timer_start[0] held high, release, keep high → channel 0 stays IDLE, output 0; drop and re-raise → busy after that edge, count 1 one cycle later.
- WIDTH 8, limit 5, one-shot, tick=1: start → counts 0..5, done pulse once, DONE holding 5; second start edge → restarts from 0.
- Periodic, limit 3, tick every 4th cycle → sequence 0,1,2,3,0,... changing only after tick edges; done every 4 ticks.
- Count to 7, stand edge → holds 7 for 10 cycles, busy low; start edge → resumes 8; reset and start edges same cycle while in STAND → IDLE, count 0.
- WIDTH 4, INIT 14, limit 2: without macro → 14,15,0,1,2 then done; with PULSE_TIMER_SATURATE_EN → holds 15, no done.
- NUM_CH 4, channels started/stopped at staggered cycles; rst asserted mid-count → all outputs INIT_VALUE next cycle, no done strobe, channels independent before reset.

Source files
------------

// File: rtl/multi_channel_pulse_timer_pkg.sv
// Shared state encodings for the multi-channel pulse timer.
package pulse_timer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'b00;
  localparam state_t ST_COUNTING = 2'b10;
  localparam state_t ST_STAND    = 2'b01;
  localparam state_t ST_DONE     = 2'b11;

endpackage

// File: rtl/multi_channel_pulse_timer_channel.sv
// One pulse timer channel: rising-edge controls, limit compare, one-shot/periodic reload.
// PULSE_TIMER_SATURATE_EN makes the counter hold at all-ones instead of wrapping.
//
// state    | meaning
// IDLE     | count parked at INIT_VALUE, waiting for start
// COUNTING | count advances on tick, compared against limit
// STAND    | paused, count held, start resumes without reload
// DONE     | one-shot finished, count held at limit
module pulse_timer_channel
  import pulse_timer_pkg::*;
#(
  parameter int unsigned           WIDTH      = 16,
  parameter logic [WIDTH-1:0]      INIT_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             stand,
  input  logic             reset_req,
  input  logic [WIDTH-1:0] limit,
  input  logic             periodic,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             busy
);

  logic             start_d, stand_d, reset_d;
  logic             start_e, stand_e, reset_e;
  state_t           state, state_n;
  logic [WIDTH-1:0] count_n, count_inc;
  logic             done_n;

  // Delay regs come out of reset high so a line held through reset cannot fire.
  assign start_e = start & ~start_d;
  assign stand_e = stand & ~stand_d;
  assign reset_e = reset_req & ~reset_d;

`ifdef PULSE_TIMER_SATURATE_EN
  assign count_inc = (count == '1) ? count : count + 1'b1;
`else
  assign count_inc = count + 1'b1;
`endif

  always_comb begin
    state_n = state;
    count_n = count;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        count_n = INIT_VALUE;
        if (reset_e)      state_n = ST_IDLE;
        else if (start_e) state_n = ST_COUNTING;
        else if (stand_e) state_n = ST_STAND;
      end
      ST_COUNTING: begin
        if (reset_e) begin
          state_n = ST_IDLE;
          count_n = INIT_VALUE;
        end else if (stand_e) begin
          state_n = ST_STAND;
        end else if (tick) begin
          if (count == limit) begin
            done_n = 1'b1;
            if (periodic) count_n = INIT_VALUE;
            else          state_n = ST_DONE;
          end else begin
            count_n = count_inc;
          end
        end
      end
      ST_STAND: begin
        if (reset_e) begin
          state_n = ST_IDLE;
          count_n = INIT_VALUE;
        end else if (start_e) begin
          state_n = ST_COUNTING;
        end
      end
      default: begin
        if (reset_e) begin
          state_n = ST_IDLE;
          count_n = INIT_VALUE;
        end else if (start_e) begin
          state_n = ST_COUNTING;
          count_n = INIT_VALUE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_d <= 1'b1;
      stand_d <= 1'b1;
      reset_d <= 1'b1;
      state   <= ST_IDLE;
      count   <= INIT_VALUE;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      start_d <= start;
      stand_d <= stand;
      reset_d <= reset_req;
      state   <= state_n;
      count   <= count_n;
      done    <= done_n;
      busy    <= (state_n == ST_COUNTING);
    end
  end

endmodule

// File: rtl/multi_channel_pulse_timer.sv
// NUM_CH independent pulse timers sharing one tick; buses packed channel i at [i*WIDTH +: WIDTH].
// Optional saturation build: PULSE_TIMER_SATURATE_EN.
module multi_channel_pulse_timer
  import pulse_timer_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned INIT_VALUE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic [NUM_CH-1:0]       timer_start,
  input  logic [NUM_CH-1:0]       timer_stand,
  input  logic [NUM_CH-1:0]       timer_reset,
  input  logic [NUM_CH*WIDTH-1:0] timer_limit,
  input  logic [NUM_CH-1:0]       timer_periodic,
  output logic [NUM_CH*WIDTH-1:0] output_timer,
  output logic [NUM_CH-1:0]       timer_done,
  output logic [NUM_CH-1:0]       timer_busy
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pulse_timer_channel #(
      .WIDTH      (WIDTH),
      .INIT_VALUE (WIDTH'(INIT_VALUE))
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .start     (timer_start[i]),
      .stand     (timer_stand[i]),
      .reset_req (timer_reset[i]),
      .limit     (timer_limit[i*WIDTH +: WIDTH]),
      .periodic  (timer_periodic[i]),
      .count     (output_timer[i*WIDTH +: WIDTH]),
      .done      (timer_done[i]),
      .busy      (timer_busy[i])
    );
  end

endmodule

// File: tb/tb_multi_channel_pulse_timer.sv
// Directed bench: 4x8-bit timer (INIT 0) plus a 1x4-bit timer (INIT 14) for wrap/saturate.
module tb_multi_channel_pulse_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [3:0]  start, stand, rreq, periodic;
  logic [31:0] limit;
  logic [31:0] out;
  logic [3:0]  done, busy;

  logic [0:0]  s_start, s_stand, s_rreq, s_periodic;
  logic [3:0]  s_limit, s_out;
  logic [0:0]  s_done, s_busy;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  multi_channel_pulse_timer #(.NUM_CH(4), .WIDTH(8), .INIT_VALUE(0)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .timer_start(start), .timer_stand(stand), .timer_reset(rreq),
    .timer_limit(limit), .timer_periodic(periodic),
    .output_timer(out), .timer_done(done), .timer_busy(busy)
  );

  multi_channel_pulse_timer #(.NUM_CH(1), .WIDTH(4), .INIT_VALUE(14)) dut_small (
    .clk(clk), .rst(rst), .tick(tick),
    .timer_start(s_start), .timer_stand(s_stand), .timer_reset(s_rreq),
    .timer_limit(s_limit), .timer_periodic(s_periodic),
    .output_timer(s_out), .timer_done(s_done), .timer_busy(s_busy)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] oc(input int i);
    return out[i*8 +: 8];
  endfunction

  initial begin
    rst = 1'b1; tick = 1'b1;
    start = 4'b0001; stand = '0; rreq = '0;
    limit = {8'd200, 8'd100, 8'd3, 8'd5};
    periodic = 4'b0010;
    s_start = '0; s_stand = '0; s_rreq = '0; s_periodic = '0; s_limit = 4'd2;
    step(2);
    chk("rst_out", out, 32'd0);
    chk("rst_busy", {28'd0, busy}, 32'd0);
    chk("rst_done", {28'd0, done}, 32'd0);
    chk("rst_small_out", {28'd0, s_out}, 32'd14);

    // start[0] held high through reset must not fire
    rst = 1'b0;
    step(1);
    chk("held_busy", {28'd0, busy}, 32'd0);
    step(3);
    chk("held_out0", {24'd0, oc(0)}, 32'd0);
    chk("held_busy2", {31'd0, busy[0]}, 32'd0);

    // one-shot, limit 5
    start[0] = 1'b0; step(1);
    start[0] = 1'b1; step(1);
    chk("os_busy_edge", {31'd0, busy[0]}, 32'd1);
    chk("os_out_edge", {24'd0, oc(0)}, 32'd0);
    step(1);
    chk("os_out_first", {24'd0, oc(0)}, 32'd1);
    step(4);
    chk("os_out5", {24'd0, oc(0)}, 32'd5);
    chk("os_nodone_yet", {31'd0, done[0]}, 32'd0);
    step(1);
    chk("os_done", {31'd0, done[0]}, 32'd1);
    chk("os_hold5", {24'd0, oc(0)}, 32'd5);
    chk("os_busy_off", {31'd0, busy[0]}, 32'd0);
    step(1);
    chk("os_done_clr", {31'd0, done[0]}, 32'd0);
    step(3);
    chk("os_still5", {24'd0, oc(0)}, 32'd5);
    start[0] = 1'b0; step(1);
    start[0] = 1'b1; step(1);
    chk("os_restart0", {24'd0, oc(0)}, 32'd0);
    chk("os_restart_busy", {31'd0, busy[0]}, 32'd1);
    step(1);
    chk("os_restart1", {24'd0, oc(0)}, 32'd1);
    rreq[0] = 1'b1; step(1);
    chk("rreq_out0", {24'd0, oc(0)}, 32'd0);
    chk("rreq_busy0", {31'd0, busy[0]}, 32'd0);
    rreq[0] = 1'b0; start[0] = 1'b0; step(1);

    // periodic, limit 3, tick every 4th cycle
    tick = 1'b0;
    start[1] = 1'b1; step(1);
    chk("per_busy", {31'd0, busy[1]}, 32'd1);
    chk("per_out0", {24'd0, oc(1)}, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick = 1'b0; step(3);
      chk("per_hold", {24'd0, oc(1)}, 32'((k - 1) % 4));
      chk("per_nodone", {31'd0, done[1]}, 32'd0);
      tick = 1'b1; step(1);
      chk("per_val", {24'd0, oc(1)}, 32'(k % 4));
      chk("per_done", {31'd0, done[1]}, (k % 4 == 0) ? 32'd1 : 32'd0);
    end
    rreq[1] = 1'b1; step(1);
    chk("per_rreq", {24'd0, oc(1)}, 32'd0);
    rreq[1] = 1'b0; start[1] = 1'b0; step(1);

    // stand / resume / reset-vs-start priority on ch2
    start[2] = 1'b1; step(1);
    chk("st_busy", {31'd0, busy[2]}, 32'd1);
    step(7);
    chk("st_out7", {24'd0, oc(2)}, 32'd7);
    stand[2] = 1'b1; step(1);
    chk("st_freeze", {24'd0, oc(2)}, 32'd7);
    chk("st_busy_off", {31'd0, busy[2]}, 32'd0);
    step(10);
    chk("st_hold10", {24'd0, oc(2)}, 32'd7);
    chk("st_busy_off2", {31'd0, busy[2]}, 32'd0);
    start[2] = 1'b0; step(1);
    start[2] = 1'b1; step(1);
    chk("st_resume", {24'd0, oc(2)}, 32'd7);
    chk("st_resume_busy", {31'd0, busy[2]}, 32'd1);
    step(1);
    chk("st_resume8", {24'd0, oc(2)}, 32'd8);
    stand[2] = 1'b0; step(1);
    stand[2] = 1'b1; step(1);
    chk("st_again", {24'd0, oc(2)}, 32'd9);
    start[2] = 1'b0; step(1);
    start[2] = 1'b1; rreq[2] = 1'b1; step(1);
    chk("st_prio_out", {24'd0, oc(2)}, 32'd0);
    chk("st_prio_busy", {31'd0, busy[2]}, 32'd0);
    step(1);
    chk("st_prio_idle", {31'd0, busy[2]}, 32'd0);
    start[2] = 1'b0; stand[2] = 1'b0; rreq[2] = 1'b0; step(1);

    // 4-bit, INIT 14, limit 2: wrap or saturate
    s_start = 1'b1; step(1);
    chk("sm_edge", {28'd0, s_out}, 32'd14);
    chk("sm_busy", {31'd0, s_busy}, 32'd1);
    step(1);
    chk("sm_15", {28'd0, s_out}, 32'd15);
`ifdef PULSE_TIMER_SATURATE_EN
    step(1); chk("sm_sat1", {28'd0, s_out}, 32'd15);
    step(1); chk("sm_sat2", {28'd0, s_out}, 32'd15);
    step(1); chk("sm_sat3", {28'd0, s_out}, 32'd15);
    step(1);
    chk("sm_sat_nodone", {31'd0, s_done}, 32'd0);
    chk("sm_sat_busy", {31'd0, s_busy}, 32'd1);
`else
    step(1); chk("sm_wrap0", {28'd0, s_out}, 32'd0);
    step(1); chk("sm_wrap1", {28'd0, s_out}, 32'd1);
    step(1);
    chk("sm_wrap2", {28'd0, s_out}, 32'd2);
    chk("sm_wrap_nodone", {31'd0, s_done}, 32'd0);
    step(1);
    chk("sm_wrap_done", {31'd0, s_done}, 32'd1);
    chk("sm_wrap_busy", {31'd0, s_busy}, 32'd0);
`endif

    // staggered channels then global reset mid-count
    limit = {4{8'd200}};
    start[0] = 1'b1; step(1);
    chk("stg_c0_edge", {24'd0, oc(0)}, 32'd0);
    step(2);
    chk("stg_c0_2", {24'd0, oc(0)}, 32'd2);
    start[3] = 1'b1; step(1);
    chk("stg_c0_3", {24'd0, oc(0)}, 32'd3);
    chk("stg_c3_0", {24'd0, oc(3)}, 32'd0);
    step(3);
    chk("stg_out", out, {8'd3, 8'd0, 8'd0, 8'd6});
    chk("stg_busy", {28'd0, busy}, 32'b1001);
    stand[0] = 1'b1; step(1);
    chk("stg_c0_stand", {24'd0, oc(0)}, 32'd6);
    chk("stg_c3_4", {24'd0, oc(3)}, 32'd4);
    step(2);
    chk("stg_out2", out, {8'd6, 8'd0, 8'd0, 8'd6});
    chk("stg_busy2", {28'd0, busy}, 32'b1000);
    rst = 1'b1; step(1);
    chk("mid_rst_out", out, 32'd0);
    chk("mid_rst_busy", {28'd0, busy}, 32'd0);
    chk("mid_rst_done", {28'd0, done}, 32'd0);
    chk("mid_rst_small", {28'd0, s_out}, 32'd14);
    rst = 1'b0; step(2);
    chk("post_rst_out", out, 32'd0);
    chk("post_rst_busy", {28'd0, busy}, 32'd0);
    chk("post_rst_done", {28'd0, done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
